// File: rtl/pbs_turn_ctrl.sv
// pbs_turn_ctrl: turn sequencer for the battle datapath.
// Accepts one player command per turn, strobes the datapath to apply it,
// waits AI_DELAY cycles, lets the AI strike back and declares the result.
// Optional feature macro: PBS_RUN_EN (op 11 ends the game as a run/draw).
// Without PBS_RUN_EN, op 11 is handshaken and silently dropped.
module pbs_turn_ctrl #(
  parameter int AI_DELAY  = 3,
  parameter int TURN_W    = 8,
  parameter int MAX_TURNS = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [1:0]        cmd_move_i,
  input  logic              ai_dead_i,
  input  logic              p_dead_i,
  input  logic              catch_success_i,
  output logic              heal_o,
  output logic              catch_o,
  output logic [1:0]        p_move_o,
  output logic              actr_o,
  output logic              app_ai_dmg_o,
  output logic              app_pl_dmg_o,
  output logic              stop_o,
  output logic [TURN_W-1:0] turn_cnt_o,
  output logic              game_over_o,
  output logic [1:0]        result_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    P_ATK   = 4'd1,
    P_HEAL  = 4'd2,
    P_CATCH = 4'd3,
    P_CHK   = 4'd4,
    AI_WAIT = 4'd5,
    AI_ATK  = 4'd6,
    AI_CHK  = 4'd7,
    DONE    = 4'd8
  } state_e;

  // Wait counter is at least one bit wide so AI_DELAY of 0 or 1 still builds.
  localparam int                 CNT_W      = (AI_DELAY < 2) ? 1 : $clog2(AI_DELAY + 1);
  localparam logic [CNT_W-1:0]   DELAY_LD   = CNT_W'(AI_DELAY);
  localparam logic [TURN_W-1:0]  TURN_SAT   = {TURN_W{1'b1}};
  localparam logic [TURN_W-1:0]  TURN_LIMIT = TURN_W'(MAX_TURNS);

  // Output bundle order: {cmd_ready, heal, catch, app_ai_dmg, app_pl_dmg, actr, stop, game_over}
  localparam logic [7:0] OUT_RESET = 8'b1000_0000;

  state_e              state_q, state_d;
  logic [1:0]          p_move_q, p_move_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [TURN_W-1:0]   turn_inc_s;
  logic [1:0]          result_q, result_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [7:0]          out_q;

  // Moore decode of a state into the control bundle; applied to the next
  // state so the controls come straight out of flops aligned with state_q.
  function automatic logic [7:0] decode_ctrl(input state_e s);
    logic [7:0] c;
    case (s)
      IDLE:    c = 8'b1000_0000;
      P_ATK:   c = 8'b0001_0010;
      P_HEAL:  c = 8'b0100_0010;
      P_CATCH: c = 8'b0010_0010;
      P_CHK:   c = 8'b0000_0010;
      AI_WAIT: c = 8'b0000_0010;
      AI_ATK:  c = 8'b0000_1110;
      AI_CHK:  c = 8'b0000_0010;
      DONE:    c = 8'b0000_0001;
      default: c = 8'b0000_0000;
    endcase
    return c;
  endfunction

  // Next-state, turn bookkeeping and result selection.
  always_comb begin
    state_d    = state_q;
    p_move_d   = p_move_q;
    turn_d     = turn_q;
    result_d   = result_q;
    wait_d     = wait_q;
    turn_inc_s = (turn_q == TURN_SAT) ? turn_q : (turn_q + {{(TURN_W-1){1'b0}}, 1'b1});
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          p_move_d = cmd_move_i;
          case (cmd_op_i)
            2'b00:   state_d = P_ATK;
            2'b01: begin
              state_d = P_HEAL;
              wait_d  = DELAY_LD;
            end
            2'b10:   state_d = P_CATCH;
            2'b11: begin
`ifdef PBS_RUN_EN
              state_d  = DONE;
              result_d = 2'b11;
`else
              state_d  = IDLE;
`endif
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      P_ATK:   state_d = P_CHK;
      P_HEAL:  state_d = AI_WAIT;
      P_CATCH: state_d = P_CHK;
      P_CHK: begin
        // A win (kill or catch) ends the game before the AI gets a turn.
        if (ai_dead_i || catch_success_i) begin
          state_d  = DONE;
          result_d = 2'b01;
        end else begin
          state_d = AI_WAIT;
          wait_d  = DELAY_LD;
        end
      end
      AI_WAIT: begin
        // Loaded value N gives N cycles here; 0 and 1 both give one cycle.
        wait_d = (wait_q == {CNT_W{1'b0}}) ? wait_q : (wait_q - {{(CNT_W-1){1'b0}}, 1'b1});
        if (wait_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = AI_ATK;
        end else begin
          state_d = AI_WAIT;
        end
      end
      AI_ATK:  state_d = AI_CHK;
      AI_CHK: begin
        turn_d = turn_inc_s;
        // A loss outranks the turn-limit draw.
        if (p_dead_i) begin
          state_d  = DONE;
          result_d = 2'b10;
        end else if ((MAX_TURNS != 0) && (turn_inc_s == TURN_LIMIT)) begin
          state_d  = DONE;
          result_d = 2'b11;
        end else begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath registers and registered control outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      p_move_q <= 2'b00;
      turn_q   <= {TURN_W{1'b0}};
      result_q <= 2'b00;
      wait_q   <= {CNT_W{1'b0}};
      out_q    <= OUT_RESET;
    end else begin
      state_q  <= state_d;
      p_move_q <= p_move_d;
      turn_q   <= turn_d;
      result_q <= result_d;
      wait_q   <= wait_d;
      out_q    <= decode_ctrl(state_d);
    end
  end

  assign cmd_ready_o  = out_q[7];
  assign heal_o       = out_q[6];
  assign catch_o      = out_q[5];
  assign app_ai_dmg_o = out_q[4];
  assign app_pl_dmg_o = out_q[3];
  assign actr_o       = out_q[2];
  assign stop_o       = out_q[1];
  assign game_over_o  = out_q[0];
  assign p_move_o     = p_move_q;
  assign turn_cnt_o   = turn_q;
  assign result_o     = result_q;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Bench for pbs_turn_ctrl (AI_DELAY=3, TURN_W=8, MAX_TURNS=2).
// Expected per-cycle output vectors are queued when a command is driven
// and popped one per clock as the DUT walks through the turn.
module tb_pbs_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_move;
  logic       ai_dead;
  logic       p_dead;
  logic       catch_success;
  logic       heal;
  logic       catch_s;
  logic [1:0] p_move;
  logic       actr;
  logic       app_ai_dmg;
  logic       app_pl_dmg;
  logic       stop;
  logic [7:0] turn_cnt;
  logic       game_over;
  logic [1:0] result;

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  pbs_turn_ctrl #(.AI_DELAY(3), .TURN_W(8), .MAX_TURNS(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_move_i(cmd_move),
    .ai_dead_i(ai_dead), .p_dead_i(p_dead), .catch_success_i(catch_success),
    .heal_o(heal), .catch_o(catch_s), .p_move_o(p_move), .actr_o(actr),
    .app_ai_dmg_o(app_ai_dmg), .app_pl_dmg_o(app_pl_dmg), .stop_o(stop),
    .turn_cnt_o(turn_cnt), .game_over_o(game_over), .result_o(result)
  );

  // Expected vector {rdy,heal,catch,ai_dmg,pl_dmg,actr,stop,game_over,result,turn_cnt,p_move}
  function automatic logic [19:0] ev(input string s, input logic [1:0] res,
                                     input logic [7:0] tc, input logic [1:0] pm);
    logic [7:0] c;
    case (s)
      "IDLE":    c = 8'b1000_0000;
      "P_ATK":   c = 8'b0001_0010;
      "P_HEAL":  c = 8'b0100_0010;
      "P_CATCH": c = 8'b0010_0010;
      "BUSY":    c = 8'b0000_0010;
      "AI_ATK":  c = 8'b0000_1110;
      "DONE":    c = 8'b0000_0001;
      default:   c = 8'hFF;
    endcase
    return {c, res, tc, pm};
  endfunction

  function automatic logic [19:0] obs();
    return {cmd_ready, heal, catch_s, app_ai_dmg, app_pl_dmg, actr, stop, game_over,
            result, turn_cnt, p_move};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_move = 2'b00;
    ai_dead = 1'b0; p_dead = 1'b0; catch_success = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    int n;
    do_reset();
    e = ev("IDLE", 2'b00, 8'd0, 2'd0);
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_init got=%h exp=%h", obs(), e); end
    // one heal turn so turn_cnt is non-zero before the mid-turn reset
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_move = 2'd1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    checks++;
    if (!cmd_ready || turn_cnt !== 8'd1) begin
      failures++; $display("FAIL reset_preturn rdy=%b tc=%0d exp rdy=1 tc=1", cmd_ready, turn_cnt);
    end
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_move = 2'd3;
    tick();                       // P_ATK
    cmd_valid = 1'b0;
    tick();                       // P_CHK
    tick();                       // AI_WAIT
    checks++;
    if (stop !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_wait stop=%b rdy=%b exp stop=1 rdy=0", stop, cmd_ready);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs(), e); end
    tick();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs(), e); end
    rst_ni = 1'b1;
    tick();
    checks++;
    if (obs() !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_attack_turn();
    logic [19:0] e;
    int i;
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_move = 2'd2;
    exp_q.push_back(ev("P_ATK",  2'b00, 8'd0, 2'd2));
    exp_q.push_back(ev("BUSY",   2'b00, 8'd0, 2'd2));
    repeat (3) exp_q.push_back(ev("BUSY", 2'b00, 8'd0, 2'd2));
    exp_q.push_back(ev("AI_ATK", 2'b00, 8'd0, 2'd2));
    exp_q.push_back(ev("BUSY",   2'b00, 8'd0, 2'd2));
    exp_q.push_back(ev("IDLE",   2'b00, 8'd1, 2'd2));
    tick();
    // commands offered while busy must be dropped
    cmd_op = 2'b10; cmd_move = 2'd0;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL attack_turn cyc%0d got=%h exp=%h", i, obs(), e); end
      if (i == 4) cmd_valid = 1'b0;
      tick();
      i++;
    end
  endtask

  task automatic test_ai_win();
    logic [19:0] e;
    int i;
    do_reset();
    ai_dead = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_move = 2'd1;
    exp_q.push_back(ev("P_ATK", 2'b00, 8'd0, 2'd1));
    exp_q.push_back(ev("BUSY",  2'b00, 8'd0, 2'd1));
    repeat (3) exp_q.push_back(ev("DONE", 2'b01, 8'd0, 2'd1));
    tick();
    cmd_valid = 1'b0;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL ai_win cyc%0d got=%h exp=%h", i, obs(), e); end
      tick();
      i++;
    end
  endtask

  task automatic test_catch_and_loss();
    logic [19:0] e;
    int i;
    do_reset();
    catch_success = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_move = 2'd3;
    exp_q.push_back(ev("P_CATCH", 2'b00, 8'd0, 2'd3));
    exp_q.push_back(ev("BUSY",    2'b00, 8'd0, 2'd3));
    repeat (2) exp_q.push_back(ev("DONE", 2'b01, 8'd0, 2'd3));
    tick();
    cmd_valid = 1'b0;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL catch_win cyc%0d got=%h exp=%h", i, obs(), e); end
      tick();
      i++;
    end
    do_reset();
    p_dead = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_move = 2'd1;
    exp_q.push_back(ev("P_HEAL", 2'b00, 8'd0, 2'd1));
    repeat (3) exp_q.push_back(ev("BUSY", 2'b00, 8'd0, 2'd1));
    exp_q.push_back(ev("AI_ATK", 2'b00, 8'd0, 2'd1));
    exp_q.push_back(ev("BUSY",   2'b00, 8'd0, 2'd1));
    repeat (2) exp_q.push_back(ev("DONE", 2'b10, 8'd1, 2'd1));
    tick();
    cmd_valid = 1'b0;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL heal_loss cyc%0d got=%h exp=%h", i, obs(), e); end
      tick();
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e;
    int i;
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_move = 2'd0;
    exp_q.push_back(ev("P_ATK", 2'b00, 8'd0, 2'd0));
    repeat (4) exp_q.push_back(ev("BUSY", 2'b00, 8'd0, 2'd0));
    exp_q.push_back(ev("AI_ATK", 2'b00, 8'd0, 2'd0));
    exp_q.push_back(ev("BUSY",   2'b00, 8'd0, 2'd0));
    exp_q.push_back(ev("IDLE",   2'b00, 8'd1, 2'd0));
    tick();
    cmd_valid = 1'b0;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, obs(), e); end
      if (i == 7) begin
        // second turn issued the moment the controller is ready again
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_move = 2'd1;
        exp_q.push_back(ev("P_HEAL", 2'b00, 8'd1, 2'd1));
        repeat (3) exp_q.push_back(ev("BUSY", 2'b00, 8'd1, 2'd1));
        exp_q.push_back(ev("AI_ATK", 2'b00, 8'd1, 2'd1));
        exp_q.push_back(ev("BUSY",   2'b00, 8'd1, 2'd1));
        repeat (3) exp_q.push_back(ev("DONE", 2'b11, 8'd2, 2'd1));
      end
      if (i == 8) cmd_valid = 1'b0;
      if (i == 14) begin
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_move = 2'd2;
      end
      tick();
      i++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_run_op();
    logic [19:0] e;
    int i;
    do_reset();
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL run_ready got=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_move = 2'd0;
`ifdef PBS_RUN_EN
    repeat (3) exp_q.push_back(ev("DONE", 2'b11, 8'd0, 2'd0));
`else
    repeat (3) exp_q.push_back(ev("IDLE", 2'b00, 8'd0, 2'd0));
`endif
    tick();
    cmd_valid = 1'b0;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin failures++; $display("FAIL run_op cyc%0d got=%h exp=%h", i, obs(), e); end
      tick();
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_attack_turn();
    test_ai_win();
    test_catch_and_loss();
    test_back_to_back();
    test_run_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
